// File: rtl/prio_pkg.sv
// Shared types and helpers for the priority arbiter.
// Holds the FSM state encoding and the highest-set-bit search.
package prio_pkg;

   localparam int MAXN = 64;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [5:0] hi_idx(
      input logic [MAXN-1:0] v
   );
      logic [5:0] r;
      r = '0;
      for (int i = 0; i < MAXN; i++) begin
         if (v[i]) r = 6'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_scan.sv
// Combinational highest-set-bit finder.
// o_idx is only meaningful when o_found is high.
module prio_scan
   import prio_pkg::*;
#(
   parameter int N  = 16,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_vec,
   output logic          o_found,
   output logic [IW-1:0] o_idx
);

   logic [MAXN-1:0] w_wide;

   always_comb begin
      w_wide         = '0;
      w_wide[N-1:0]  = i_vec;
   end

   assign o_found = |i_vec;
   assign o_idx   = IW'(hi_idx(w_wide));

endmodule

// File: rtl/prio_arbiter.sv
// Single-grant arbiter, fixed priority or round-robin.
// A grant is held until ack; the winner is latched on entry.
module prio_arbiter
   import prio_pkg::*;
#(
   parameter int N       = 16,
   parameter int RR_MODE = 0,
   parameter int IW      = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          ack,
   output logic          gnt_valid,
   output logic [IW-1:0] gnt_idx,
   output logic [N-1:0]  gnt_oh,
   output logic          busy
);

   localparam logic [IW-1:0] PTR_RST = IW'(N-1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_ptr_nxt;
   logic [IW-1:0] r_idx;
   logic [IW-1:0] w_idx_nxt;
   logic [N-1:0]  r_oh;
   logic [N-1:0]  w_oh_nxt;

   logic          w_found;
   logic          w_found_u;
   logic [IW-1:0] w_idx_u;
   logic [IW-1:0] w_win;

   prio_scan #(
      .N  (N),
      .IW (IW)
   ) u_scan_all (
      .i_vec   (req),
      .o_found (w_found_u),
      .o_idx   (w_idx_u)
   );

   assign w_found = w_found_u;

   generate
      if (RR_MODE != 0) begin : g_rr
         logic [N-1:0]  w_mask;
         logic [N-1:0]  w_req_m;
         logic          w_found_m;
         logic [IW-1:0] w_idx_m;

         // Bits at or below ptr are searched first; wrap-around
         // falls back to the unmasked search.
         for (genvar i = 0; i < N; i++) begin : g_mask
            assign w_mask[i] = (IW'(i) <= r_ptr);
         end

         assign w_req_m = req & w_mask;

         prio_scan #(
            .N  (N),
            .IW (IW)
         ) u_scan_msk (
            .i_vec   (w_req_m),
            .o_found (w_found_m),
            .o_idx   (w_idx_m)
         );

         assign w_win = w_found_m ? w_idx_m : w_idx_u;
      end else begin : g_fix
         assign w_win = w_idx_u;
      end
   endgenerate

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_oh_nxt    = r_oh;
      w_ptr_nxt   = r_ptr;
      unique case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_nxt = GRANT;
               w_idx_nxt   = w_win;
               w_oh_nxt    = N'(1) << w_win;
            end
         end
         GRANT: begin
            if (ack) begin
               w_state_nxt = IDLE;
               w_idx_nxt   = '0;
               w_oh_nxt    = '0;
               if (RR_MODE != 0) begin
                  if (r_idx == '0) w_ptr_nxt = PTR_RST;
                  else             w_ptr_nxt = r_idx - IW'(1);
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_oh    <= '0;
         r_ptr   <= PTR_RST;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_oh    <= w_oh_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   assign gnt_valid = (r_state == GRANT);
   assign busy      = (r_state == GRANT);
   assign gnt_idx   = r_idx;
   assign gnt_oh    = r_oh;

   a_onehot: assert property (
      @(posedge clk) disable iff (rst)
      gnt_valid |-> $onehot(gnt_oh)
   );

   a_idle_zero: assert property (
      @(posedge clk) disable iff (rst)
      !gnt_valid |-> (gnt_oh == '0)
   );

   a_idx_range: assert property (
      @(posedge clk) disable iff (rst)
      gnt_idx <= PTR_RST
   );

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter: fixed N=16, RR N=16 and RR N=5
// instances, table vectors, directed corners and random traffic.
module tb_prio_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_v [3];
   logic        ack_v [3];
   logic [63:0] req_v [3];

   logic        v0, v1, v2;
   logic        b0, b1, b2;
   logic [3:0]  ix0, ix1;
   logic [2:0]  ix2;
   logic [15:0] oh0, oh1;
   logic [4:0]  oh2;

   prio_arbiter #(.N(16), .RR_MODE(0)) dut0 (
      .clk(clk), .rst(rst_v[0]), .req(req_v[0][15:0]),
      .ack(ack_v[0]), .gnt_valid(v0), .gnt_idx(ix0),
      .gnt_oh(oh0), .busy(b0)
   );

   prio_arbiter #(.N(16), .RR_MODE(1)) dut1 (
      .clk(clk), .rst(rst_v[1]), .req(req_v[1][15:0]),
      .ack(ack_v[1]), .gnt_valid(v1), .gnt_idx(ix1),
      .gnt_oh(oh1), .busy(b1)
   );

   prio_arbiter #(.N(5), .RR_MODE(1)) dut2 (
      .clk(clk), .rst(rst_v[2]), .req(req_v[2][4:0]),
      .ack(ack_v[2]), .gnt_valid(v2), .gnt_idx(ix2),
      .gnt_oh(oh2), .busy(b2)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a grant is "granted flag + index", the
   // round-robin scan walks downward from ptr with modulo wrap.
   int NN [3] = '{16, 16, 5};
   bit RR [3] = '{1'b0, 1'b1, 1'b1};
   bit m_g   [3];
   int m_idx [3];
   int m_ptr [3];

   function automatic int winner(int d, logic [63:0] r);
      if (!RR[d]) begin
         for (int i = NN[d] - 1; i >= 0; i--)
            if (r[i]) return i;
      end else begin
         for (int k = 0; k < NN[d]; k++) begin
            int c;
            c = (m_ptr[d] - k + NN[d]) % NN[d];
            if (r[c]) return c;
         end
      end
      return -1;
   endfunction

   task automatic model_step(int d);
      logic [63:0] r;
      int w;
      r = req_v[d] & ((64'd1 << NN[d]) - 64'd1);
      if (rst_v[d]) begin
         m_g[d] = 1'b0;
         m_idx[d] = 0;
         m_ptr[d] = NN[d] - 1;
      end else if (m_g[d]) begin
         if (ack_v[d]) begin
            m_g[d] = 1'b0;
            if (RR[d]) m_ptr[d] = (m_idx[d] + NN[d] - 1) % NN[d];
            m_idx[d] = 0;
         end
      end else begin
         w = winner(d, r);
         if (w >= 0) begin
            m_g[d] = 1'b1;
            m_idx[d] = w;
         end
      end
   endtask

   task automatic read_out(input int d, output logic [63:0] v,
                           output logic [63:0] ix, output logic [63:0] oh,
                           output logic [63:0] b, output logic [63:0] p);
      case (d)
         0: begin
            v = 64'(v0); ix = 64'(ix0); oh = 64'(oh0);
            b = 64'(b0); p = 64'(dut0.r_ptr);
         end
         1: begin
            v = 64'(v1); ix = 64'(ix1); oh = 64'(oh1);
            b = 64'(b1); p = 64'(dut1.r_ptr);
         end
         default: begin
            v = 64'(v2); ix = 64'(ix2); oh = 64'(oh2);
            b = 64'(b2); p = 64'(dut2.r_ptr);
         end
      endcase
   endtask

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   task automatic cmp_model(int d);
      logic [63:0] v, ix, oh, b, p, eoh;
      read_out(d, v, ix, oh, b, p);
      eoh = m_g[d] ? (64'd1 << m_idx[d]) : 64'd0;
      chk($sformatf("mdl%0d.vld", d), v, 64'(m_g[d]));
      chk($sformatf("mdl%0d.idx", d), ix, 64'(m_idx[d]));
      chk($sformatf("mdl%0d.oh", d), oh, eoh);
      chk($sformatf("mdl%0d.busy", d), b, 64'(m_g[d]));
      if (RR[d]) chk($sformatf("mdl%0d.ptr", d), p, 64'(m_ptr[d]));
      else       chk($sformatf("mdl%0d.ptr", d), p, 64'(NN[d] - 1));
   endtask

   task automatic step();
      for (int d = 0; d < 3; d++) model_step(d);
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) cmp_model(d);
   endtask

   task automatic drive(int d, logic r, logic a, logic [63:0] q);
      rst_v[d] = r;
      ack_v[d] = a;
      req_v[d] = q;
   endtask

   typedef struct {
      logic        rst;
      logic        ack;
      logic [15:0] req;
      logic        vld;
      logic [3:0]  idx;
      logic [15:0] oh;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [63:0] v, ix, oh, b, p;
      int ex_idx [4];
      int ex_ptr [4];
      int ex5 [3];

      tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'd0,  16'h0000};
      tbl[1]  = '{1'b0, 1'b0, 16'h8421, 1'b1, 4'd15, 16'h8000};
      tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'd15, 16'h8000};
      tbl[3]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 4'd0,  16'h0000};
      tbl[4]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 4'd0,  16'h0000};
      tbl[5]  = '{1'b0, 1'b0, 16'h0030, 1'b1, 4'd5,  16'h0020};
      tbl[6]  = '{1'b0, 1'b1, 16'h0030, 1'b0, 4'd0,  16'h0000};
      tbl[7]  = '{1'b0, 1'b0, 16'h0001, 1'b1, 4'd0,  16'h0001};
      tbl[8]  = '{1'b0, 1'b1, 16'hffff, 1'b0, 4'd0,  16'h0000};
      tbl[9]  = '{1'b0, 1'b0, 16'hffff, 1'b1, 4'd15, 16'h8000};
      tbl[10] = '{1'b1, 1'b1, 16'h0000, 1'b0, 4'd0,  16'h0000};

      for (int d = 0; d < 3; d++) drive(d, 1'b1, 1'b0, 64'd0);
      step();
      for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 64'd0);

      // Table vectors on the fixed-priority instance.
      for (int i = 0; i < 11; i++) begin
         drive(0, tbl[i].rst, tbl[i].ack, 64'(tbl[i].req));
         step();
         read_out(0, v, ix, oh, b, p);
         chk($sformatf("tbl%0d.vld", i), v, 64'(tbl[i].vld));
         chk($sformatf("tbl%0d.idx", i), ix, 64'(tbl[i].idx));
         chk($sformatf("tbl%0d.oh", i), oh, 64'(tbl[i].oh));
      end
      drive(0, 1'b0, 1'b0, 64'd0);

      // Round-robin rotation with ack held high.
      ex_idx = '{8, 4, 0, 8};
      ex_ptr = '{7, 3, 15, 7};
      drive(1, 1'b0, 1'b1, 64'h0111);
      for (int i = 0; i < 4; i++) begin
         step();
         read_out(1, v, ix, oh, b, p);
         chk($sformatf("rr16.g%0d.idx", i), ix, 64'(ex_idx[i]));
         chk($sformatf("rr16.g%0d.vld", i), v, 64'd1);
         step();
         read_out(1, v, ix, oh, b, p);
         chk($sformatf("rr16.g%0d.ptr", i), p, 64'(ex_ptr[i]));
         chk($sformatf("rr16.g%0d.gap", i), v, 64'd0);
      end

      // Grant holds while the request is withdrawn.
      drive(1, 1'b1, 1'b0, 64'd0);
      step();
      drive(1, 1'b0, 1'b0, 64'h0010);
      step();
      drive(1, 1'b0, 1'b0, 64'h0000);
      for (int i = 0; i < 3; i++) begin
         step();
         read_out(1, v, ix, oh, b, p);
         chk($sformatf("hold%0d.idx", i), ix, 64'd4);
         chk($sformatf("hold%0d.vld", i), v, 64'd1);
      end
      drive(1, 1'b0, 1'b1, 64'h0000);
      step();
      read_out(1, v, ix, oh, b, p);
      chk("hold.ackd.vld", v, 64'd0);

      // Reset beats a simultaneous ack, ptr untouched.
      drive(1, 1'b0, 1'b0, 64'h0010);
      step();
      drive(1, 1'b1, 1'b1, 64'h0010);
      step();
      read_out(1, v, ix, oh, b, p);
      chk("rstack.vld", v, 64'd0);
      chk("rstack.idx", ix, 64'd0);
      chk("rstack.oh", oh, 64'd0);
      chk("rstack.busy", b, 64'd0);
      chk("rstack.ptr", p, 64'd15);

      // Ack in IDLE is ignored.
      drive(1, 1'b0, 1'b1, 64'h0000);
      step();
      step();
      read_out(1, v, ix, oh, b, p);
      chk("idleack.vld", v, 64'd0);
      chk("idleack.ptr", p, 64'd15);

      // N=5 round-robin.
      ex5 = '{4, 0, 4};
      drive(2, 1'b0, 1'b1, 64'h11);
      for (int i = 0; i < 3; i++) begin
         step();
         read_out(2, v, ix, oh, b, p);
         chk($sformatf("rr5.g%0d.idx", i), ix, 64'(ex5[i]));
         chk($sformatf("rr5.g%0d.range", i), 64'(ix <= 64'd4), 64'd1);
         step();
      end

      // Random traffic, all instances against the model.
      for (int c = 0; c < 3000; c++) begin
         for (int d = 0; d < 3; d++) begin
            logic [63:0] q;
            q = {$urandom, $urandom};
            case ($urandom_range(0, 3))
               0: q = 64'd0;
               1: q = q & {$urandom, $urandom} & {$urandom, $urandom};
               2: q = 64'd1 << $urandom_range(0, 15);
               default: ;
            endcase
            drive(d, ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 2) == 0), q);
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 Parameter N, default 16: number of request lines; legal range 2..64.
REQ-002 Parameter RR_MODE, default 0: 0 = fixed priority, 1 = round-robin.
REQ-003 Parameter IW, default $clog2(N): width of the grant index; derived, never overridden.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 req  input  N: request vector; bit i high = requester i active.
REQ-007 ack  input  1: consumer accepts the current grant.
REQ-008 gnt_valid  output  1: a grant is presented.
REQ-009 gnt_idx  output  IW: index of the granted requester.
REQ-010 gnt_oh  output  N: one-hot form of gnt_idx; all-zero when gnt_valid=0.
REQ-011 busy  output  1: high in GRANT state.

Function
REQ-012 FSM has two states, IDLE and GRANT; reset state IDLE.
REQ-013 IDLE: if req != 0 at a rising edge, latch winner into gnt_idx/gnt_oh and enter GRANT; gnt_valid=1 from the next cycle (latency 1).
REQ-014 IDLE with req == 0: remain in IDLE; outputs hold reset values.
REQ-015 Fixed mode: winner = highest-index set bit of req (bit N-1 highest priority).
REQ-016 RR mode: winner = first set bit scanning downward from ptr to 0, then wrapping from N-1 down to ptr+1.
REQ-017 ptr is IW bits, reset to N-1; updated only on an accepted grant to (gnt_idx-1) mod N, so index 0 wraps to N-1.
REQ-018 GRANT: gnt_idx, gnt_oh and gnt_valid hold stable regardless of req changes, including withdrawal of the granted request.
REQ-019 GRANT with ack=1: return to IDLE; gnt_valid=0 and gnt_oh=0 in the next cycle; minimum spacing between grants is 2 cycles.
REQ-020 ack in IDLE is ignored; it has no effect on state or ptr.
REQ-021 Bits of req with index >= N do not exist; gnt_idx never exceeds N-1.
REQ-022 Fixed mode keeps ptr constant at N-1; ptr logic may be optimised away.

Reset
REQ-023 On rst=1 at a rising edge: state=IDLE, gnt_valid=0, gnt_idx=0, gnt_oh=0, busy=0, ptr=N-1.
REQ-024 rst during GRANT drops the grant in the next cycle with no ptr update; rst dominates a simultaneous ack.

Structure
REQ-025 Package prio_pkg holds the state enum (IDLE, GRANT) and a function returning the highest set index of a vector.
REQ-026 One combinational sub-module, prio_scan, takes vector in and produces found, idx (highest set bit).
REQ-027 RR mode uses two prio_scan instances: one on req masked to bits <= ptr, one on unmasked req; the masked result wins when found.

Verification
REQ-028 N=16 fixed: req=0x8421 in IDLE -> next cycle gnt_valid=1, gnt_idx=15, gnt_oh=0x8000.
REQ-029 N=16 RR: req held at 0x0111 with ack on every grant -> gnt_idx sequence 8,4,0,8 with ptr wrap 15->7->3->15.
REQ-030 Hold: grant idx 4, req switches to 0x0000 before ack -> gnt_idx stays 4 and gnt_valid stays 1 until ack.
REQ-031 rst asserted in GRANT together with ack -> next cycle all outputs 0, ptr=15, state IDLE.
REQ-032 ack pulse with req=0 in IDLE -> no grant, ptr unchanged, gnt_valid remains 0.
REQ-033 N=5 RR: req=0x11 -> grants 4 then 0 then 4; gnt_idx never exceeds 4.
